hazard_ctrl: RTL

- Pipeline hazard controller for the 5-stage MIPS core.
- Sequences the IF/ID/EX pipeline registers and PC around three events:
  - load-use data hazards that forwarding cannot cover;
  - multi-cycle multiply/divide unit (MDU) occupancy;
  - taken-branch flushes.
- Sits beside the forwarding unit. It drives the PC write enable, the IF/ID write and flush controls, and the ID/EX bubble insert.

---
 rtl/hazard_pkg.sv | 9 +
 rtl/hazard_ctrl_mdu_stall_counter.sv | 18 +
 rtl/hazard_ctrl.sv | 76 +++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the pipeline hazard controller
package hazard_pkg;
  typedef enum logic {RUN, MDU_WAIT} state_t;
  localparam int REG_ADDR_W_DEF = 5;
  localparam int unsigned ZERO_REG = 0;
  localparam int CNT_W = 4;
  localparam int STALL_CNT_W = 32;
  localparam int FLUSH_CNT_W = 16;
endpackage

// File: rtl/hazard_ctrl_mdu_stall_counter.sv
// mdu_stall_counter: loadable down-counter, holds at zero; done = (cnt == 0)
// Ports: clk, rst_n (async active-low), load, load_value, done.
module mdu_stall_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic         done
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (load) cnt <= load_value;
    else if (cnt != '0) cnt <= cnt - 1'b1;
  assign done = cnt == '0;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use / MDU-occupancy / taken-branch stall and flush sequencing
// Ports: clk, rst_n (async active-low); ex_mem_read, ex_rt, id_rs, id_rt, id_uses_rt,
// id_mdu_start, ex_branch_taken in; pc_write, if_id_write, if_id_flush, id_ex_bubble,
// mdu_busy out. HAZARD_PERF_EN adds stall_cycles and flush_count saturating counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W  = REG_ADDR_W_DEF,
  parameter int MDU_LATENCY = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ex_mem_read,
  input  logic [REG_ADDR_W-1:0]  ex_rt,
  input  logic [REG_ADDR_W-1:0]  id_rs,
  input  logic [REG_ADDR_W-1:0]  id_rt,
  input  logic                   id_uses_rt,
  input  logic                   id_mdu_start,
  input  logic                   ex_branch_taken,
  output logic                   pc_write,
  output logic                   if_id_write,
  output logic                   if_id_flush,
  output logic                   id_ex_bubble,
`ifdef HAZARD_PERF_EN
  output logic [STALL_CNT_W-1:0] stall_cycles,
  output logic [FLUSH_CNT_W-1:0] flush_count,
`endif
  output logic                   mdu_busy
);
  if (MDU_LATENCY < 1 || MDU_LATENCY > 15) begin : g_bad_latency
    $error("hazard_ctrl: MDU_LATENCY must be in 1..15");
  end
  state_t state, state_d;
  logic load_use, stall, flush, start, done;
  assign load_use = ex_mem_read && ex_rt != REG_ADDR_W'(ZERO_REG) &&
                    (ex_rt == id_rs || (id_uses_rt && ex_rt == id_rt));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= RUN;
    else state <= state_d;
  always_comb begin
    state_d = state;
    stall = 1'b0;
    flush = 1'b0;
    start = 1'b0;
    if (state == MDU_WAIT) begin
      stall = 1'b1;
      state_d = done ? RUN : MDU_WAIT;
    end else if (ex_branch_taken) flush = 1'b1;
    else if (load_use) stall = 1'b1;
    else if (id_mdu_start) begin
      start = 1'b1;
      state_d = MDU_WAIT;
    end
  end
  // counter is loaded with LATENCY-1 so the wait lasts exactly LATENCY cycles
  mdu_stall_counter #(.W(CNT_W)) u_cnt (
    .clk(clk), .rst_n(rst_n), .load(start),
    .load_value(CNT_W'(MDU_LATENCY - 1)), .done(done)
  );
  // gating with rst_n keeps outputs at reset values while reset is held
  assign pc_write     = !rst_n || !stall;
  assign if_id_write  = !rst_n || !stall;
  assign if_id_flush  = rst_n && flush;
  assign id_ex_bubble = rst_n && (stall || flush);
  assign mdu_busy     = rst_n && state == MDU_WAIT;
`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      stall_cycles <= '0;
      flush_count <= '0;
    end else begin
      if (!pc_write && stall_cycles != '1) stall_cycles <= stall_cycles + 1'b1;
      if (if_id_flush && flush_count != '1) flush_count <= flush_count + 1'b1;
    end
`endif
endmodule
